// File: rtl/ctrl_pkg.sv
// Shared definitions for the ID-stage controller: opcodes, execute
// commands, branch-condition codes and the ID/EX control bundle.
package ctrl_pkg;

    // Opcode map (BEQ/BLT are the newest additions).
    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_AND  = 6'd3;
    localparam logic [5:0] OP_SLL  = 6'd4;
    localparam logic [5:0] OP_ADDI = 6'd5;
    localparam logic [5:0] OP_LW   = 6'd6;
    localparam logic [5:0] OP_SW   = 6'd7;
    localparam logic [5:0] OP_CLR  = 6'd8;
    localparam logic [5:0] OP_CMP  = 6'd9;
    localparam logic [5:0] OP_BNE  = 6'd10;
    localparam logic [5:0] OP_JMP  = 6'd11;
    localparam logic [5:0] OP_MULT = 6'd12;
    localparam logic [5:0] OP_BEQ  = 6'd13;
    localparam logic [5:0] OP_BLT  = 6'd14;

    // Execute-stage commands.
    localparam logic [3:0] EXE_NOP  = 4'd0;
    localparam logic [3:0] EXE_ADD  = 4'd1;
    localparam logic [3:0] EXE_SUB  = 4'd2;
    localparam logic [3:0] EXE_AND  = 4'd3;
    localparam logic [3:0] EXE_SLL  = 4'd4;
    localparam logic [3:0] EXE_CLR  = 4'd5;
    localparam logic [3:0] EXE_MULT = 4'd6;

    // Branch conditions evaluated against the architectural flags.
    localparam logic [2:0] COND_NONE = 3'd0;
    localparam logic [2:0] COND_NE   = 3'd1;
    localparam logic [2:0] COND_EQ   = 3'd2;
    localparam logic [2:0] COND_LT   = 3'd3;
    localparam logic [2:0] COND_AL   = 3'd4;

    // ID/EX control bundle; all-zero is a bubble.
    typedef struct packed {
        logic       ex_valid;
        logic [3:0] exe_cmd;
        logic       is_imm;
        logic       st_or_bne;
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       jump_en;
    } ctrl_bundle_t;

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Handshake/bus signals between the ID stage and the decode/issue controller.
interface pipe_ctrl_unit_if #(
    parameter int OPC_W     = 6,
    parameter int WORD_W    = 32,
    parameter int EXE_CMD_W = 4
);
    logic                 in_valid;
    logic [OPC_W-1:0]     opcode;
    logic [WORD_W-1:0]    src1;
    logic [WORD_W-1:0]    src2;
    logic                 hazard;
    logic                 flush;

    logic                 ex_valid;
    logic [EXE_CMD_W-1:0] exe_cmd;
    logic                 is_imm;
    logic                 st_or_bne;
    logic                 wb_en;
    logic                 mem_r_en;
    logic                 mem_w_en;
    logic                 branch_taken;
    logic                 jump_en;
    logic                 flag_z;
    logic                 flag_n;
    logic                 stall_out;
    logic                 illegal_op;

    modport master (
        output in_valid, opcode, src1, src2, hazard, flush,
        input  ex_valid, exe_cmd, is_imm, st_or_bne, wb_en, mem_r_en, mem_w_en,
               branch_taken, jump_en, flag_z, flag_n, stall_out, illegal_op
    );

    modport slave (
        input  in_valid, opcode, src1, src2, hazard, flush,
        output ex_valid, exe_cmd, is_imm, st_or_bne, wb_en, mem_r_en, mem_w_en,
               branch_taken, jump_en, flag_z, flag_n, stall_out, illegal_op
    );
endinterface

// File: rtl/cond_flags.sv
// Architectural Z/N flags, the CMP subtractor and branch-condition evaluation.
module cond_flags
    import ctrl_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmp_we,
    input  logic [WORD_W-1:0] src1,
    input  logic [WORD_W-1:0] src2,
    input  logic [2:0]        cond,
    output logic              flag_z,
    output logic              flag_n,
    output logic              taken
);
    // One extra bit so the sign of the difference never wraps.
    logic signed [WORD_W:0] diff;
    assign diff = $signed({src1[WORD_W-1], src1}) - $signed({src2[WORD_W-1], src2});

    logic z_reg;
    logic n_reg;

    // Flags change only on an accepted CMP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_reg <= 1'b0;
            n_reg <= 1'b0;
        end else if (cmp_we) begin
            z_reg <= (diff == '0);
            n_reg <= diff[WORD_W];
        end
    end

    // Branch resolution uses the registered flags only.
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_NE: taken = ~z_reg;
            COND_EQ: taken = z_reg;
            COND_LT: taken = n_reg;
            COND_AL: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    assign flag_z = z_reg;
    assign flag_n = n_reg;
endmodule

// File: rtl/pipe_ctrl_unit.sv
// Registered ID-stage decode/issue controller with MULT busy sequencing.
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int OPC_W     = 6,
    parameter int WORD_W    = 32,
    parameter int EXE_CMD_W = 4,
    parameter int MULT_LAT  = 4
) (
    input logic             clk,
    input logic             rst,
    pipe_ctrl_unit_if.slave bus
);
    localparam int CNT_W = $clog2(MULT_LAT + 1);
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    ctrl_bundle_t dec;
    logic [2:0]   dec_cond;
    logic         dec_legal;
    logic         dec_cmp;
    logic         dec_mult;
    logic         accept;
    logic         taken;

    ctrl_bundle_t bundle_reg, bundle_next;
    logic         taken_reg, taken_next;
    logic         illegal_reg, illegal_next;
    logic         stall_reg, stall_next;
    logic [0:0]   state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    assign accept = bus.in_valid & ~bus.hazard & ~bus.flush & ~stall_reg;

    // Opcode decode into the control bundle and branch condition.
    always_comb begin
        dec          = '0;
        dec.ex_valid = 1'b1;
        dec_cond     = COND_NONE;
        dec_legal    = 1'b1;
        dec_cmp      = 1'b0;
        dec_mult     = 1'b0;
        case (bus.opcode)
            OPC_W'(OP_NOP):  ;
            OPC_W'(OP_ADD):  begin dec.exe_cmd = EXE_ADD; dec.wb_en = 1'b1; end
            OPC_W'(OP_SUB):  begin dec.exe_cmd = EXE_SUB; dec.wb_en = 1'b1; end
            OPC_W'(OP_AND):  begin dec.exe_cmd = EXE_AND; dec.wb_en = 1'b1; end
            OPC_W'(OP_SLL):  begin dec.exe_cmd = EXE_SLL; dec.wb_en = 1'b1; end
            OPC_W'(OP_ADDI): begin dec.exe_cmd = EXE_ADD; dec.wb_en = 1'b1; dec.is_imm = 1'b1; end
            OPC_W'(OP_LW): begin
                dec.exe_cmd   = EXE_ADD;
                dec.wb_en     = 1'b1;
                dec.is_imm    = 1'b1;
                dec.st_or_bne = 1'b1;
                dec.mem_r_en  = 1'b1;
            end
            OPC_W'(OP_SW): begin
                dec.is_imm    = 1'b1;
                dec.st_or_bne = 1'b1;
                dec.mem_w_en  = 1'b1;
            end
            OPC_W'(OP_CLR):  begin dec.exe_cmd = EXE_CLR; dec.wb_en = 1'b1; end
            OPC_W'(OP_CMP):  dec_cmp = 1'b1;
            OPC_W'(OP_BNE):  begin dec.is_imm = 1'b1; dec.st_or_bne = 1'b1; dec_cond = COND_NE; end
            OPC_W'(OP_BEQ):  begin dec.is_imm = 1'b1; dec_cond = COND_EQ; end
            OPC_W'(OP_BLT):  begin dec.is_imm = 1'b1; dec_cond = COND_LT; end
            OPC_W'(OP_JMP):  begin dec.is_imm = 1'b1; dec.jump_en = 1'b1; dec_cond = COND_AL; end
            OPC_W'(OP_MULT): begin dec.exe_cmd = EXE_MULT; dec.wb_en = 1'b1; dec_mult = 1'b1; end
            default: begin
                dec       = '0;
                dec_legal = 1'b0;
            end
        endcase
    end

    cond_flags #(.WORD_W(WORD_W)) u_cond_flags (
        .clk    (clk),
        .rst    (rst),
        .cmp_we (accept & dec_cmp),
        .src1   (bus.src1),
        .src2   (bus.src2),
        .cond   (dec_cond),
        .flag_z (bus.flag_z),
        .flag_n (bus.flag_n),
        .taken  (taken)
    );

    // Next bundle and MULT busy FSM; flush overrides everything.
    always_comb begin
        bundle_next  = '0;
        taken_next   = 1'b0;
        illegal_next = 1'b0;
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        stall_next   = stall_reg;
        if (bus.flush) begin
            state_next = ST_RUN;
            cnt_next   = '0;
            stall_next = 1'b0;
        end else begin
            if (state_reg == ST_BUSY) begin
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = ST_RUN;
                    stall_next = 1'b0;
                end
            end
            if (accept) begin
                if (dec_legal) begin
                    bundle_next = dec;
                    taken_next  = taken;
                end else begin
                    illegal_next = 1'b1;
                end
                if (dec_mult && (MULT_LAT > 1)) begin
                    state_next = ST_BUSY;
                    cnt_next   = CNT_W'(MULT_LAT - 1);
                    stall_next = 1'b1;
                end
            end
        end
    end

    // Output register and FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bundle_reg  <= '0;
            taken_reg   <= 1'b0;
            illegal_reg <= 1'b0;
            stall_reg   <= 1'b0;
            state_reg   <= ST_RUN;
            cnt_reg     <= '0;
        end else begin
            bundle_reg  <= bundle_next;
            taken_reg   <= taken_next;
            illegal_reg <= illegal_next;
            stall_reg   <= stall_next;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
        end
    end

    assign bus.ex_valid     = bundle_reg.ex_valid;
    assign bus.exe_cmd      = EXE_CMD_W'(bundle_reg.exe_cmd);
    assign bus.is_imm       = bundle_reg.is_imm;
    assign bus.st_or_bne    = bundle_reg.st_or_bne;
    assign bus.wb_en        = bundle_reg.wb_en;
    assign bus.mem_r_en     = bundle_reg.mem_r_en;
    assign bus.mem_w_en     = bundle_reg.mem_w_en;
    assign bus.jump_en      = bundle_reg.jump_en;
    assign bus.branch_taken = taken_reg;
    assign bus.illegal_op   = illegal_reg;
    assign bus.stall_out    = stall_reg;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: a per-cycle reference model plus
// directed vectors with hand-computed expectations.
module tb_pipe_ctrl_unit;
    import ctrl_pkg::*;

    localparam int OPC_W     = 6;
    localparam int WORD_W    = 32;
    localparam int EXE_CMD_W = 4;
    localparam int MULT_LAT  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_unit_if #(.OPC_W(OPC_W), .WORD_W(WORD_W), .EXE_CMD_W(EXE_CMD_W)) bus ();

    pipe_ctrl_unit #(
        .OPC_W(OPC_W), .WORD_W(WORD_W), .EXE_CMD_W(EXE_CMD_W), .MULT_LAT(MULT_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state and expected outputs.
    bit         m_z, m_n;
    int         m_busy;
    bit         e_valid, e_imm, e_sb, e_wb, e_mr, e_mw, e_taken, e_jmp, e_ill;
    logic [3:0] e_cmd;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit     acc;
        longint d;
        if (rst) begin
            m_z = 0; m_n = 0; m_busy = 0;
            e_valid = 0; e_imm = 0; e_sb = 0; e_wb = 0; e_mr = 0; e_mw = 0;
            e_taken = 0; e_jmp = 0; e_ill = 0; e_cmd = 0;
            return;
        end
        acc = bus.in_valid && !bus.hazard && !bus.flush && (m_busy == 0);
        e_valid = 0; e_imm = 0; e_sb = 0; e_wb = 0; e_mr = 0; e_mw = 0;
        e_taken = 0; e_jmp = 0; e_ill = 0; e_cmd = EXE_NOP;
        if (bus.flush) m_busy = 0;
        else if (m_busy > 0) m_busy--;
        if (acc) begin
            e_valid = 1;
            case (bus.opcode)
                OP_NOP:  ;
                OP_ADD:  begin e_cmd = EXE_ADD; e_wb = 1; end
                OP_SUB:  begin e_cmd = EXE_SUB; e_wb = 1; end
                OP_AND:  begin e_cmd = EXE_AND; e_wb = 1; end
                OP_SLL:  begin e_cmd = EXE_SLL; e_wb = 1; end
                OP_ADDI: begin e_cmd = EXE_ADD; e_wb = 1; e_imm = 1; end
                OP_LW:   begin e_cmd = EXE_ADD; e_wb = 1; e_imm = 1; e_sb = 1; e_mr = 1; end
                OP_SW:   begin e_imm = 1; e_sb = 1; e_mw = 1; end
                OP_CLR:  begin e_cmd = EXE_CLR; e_wb = 1; end
                OP_CMP: begin
                    d   = longint'($signed(bus.src1)) - longint'($signed(bus.src2));
                    m_z = (d == 0);
                    m_n = (d < 0);
                end
                OP_BNE:  begin e_imm = 1; e_sb = 1; e_taken = !m_z; end
                OP_BEQ:  begin e_imm = 1; e_taken = m_z; end
                OP_BLT:  begin e_imm = 1; e_taken = m_n; end
                OP_JMP:  begin e_imm = 1; e_jmp = 1; e_taken = 1; end
                OP_MULT: begin e_cmd = EXE_MULT; e_wb = 1; m_busy = MULT_LAT - 1; end
                default: begin e_valid = 0; e_ill = 1; end
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("ex_valid", bus.ex_valid, e_valid);
            chk("exe_cmd", bus.exe_cmd, e_cmd);
            chk("is_imm", bus.is_imm, e_imm);
            chk("st_or_bne", bus.st_or_bne, e_sb);
            chk("wb_en", bus.wb_en, e_wb);
            chk("mem_r_en", bus.mem_r_en, e_mr);
            chk("mem_w_en", bus.mem_w_en, e_mw);
            chk("branch_taken", bus.branch_taken, e_taken);
            chk("jump_en", bus.jump_en, e_jmp);
            chk("flag_z", bus.flag_z, m_z);
            chk("flag_n", bus.flag_n, m_n);
            chk("stall_out", bus.stall_out, m_busy > 0);
            chk("illegal_op", bus.illegal_op, e_ill);
        end
    end

    task automatic step(input logic v, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic hz, input logic fl);
        bus.in_valid = v;
        bus.opcode   = op;
        bus.src1     = a;
        bus.src2     = b;
        bus.hazard   = hz;
        bus.flush    = fl;
        @(posedge clk);
        #2;
    endtask

    logic [5:0] simple_ops [10];

    initial begin
        simple_ops = '{OP_ADD, OP_SUB, OP_AND, OP_SLL, OP_ADDI, OP_LW, OP_SW, OP_CLR, OP_NOP, OP_JMP};
        rst = 1'b1;
        bus.in_valid = 0; bus.opcode = 0; bus.src1 = 0; bus.src2 = 0;
        bus.hazard = 0; bus.flush = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset ex_valid", bus.ex_valid, 0);
        chk("reset stall", bus.stall_out, 0);
        chk("reset flag_z", bus.flag_z, 0);
        rst = 1'b0;

        // CMP equal then BEQ
        step(1, OP_CMP, 32'd5, 32'd5, 0, 0);
        chk("cmp55 flag_z", bus.flag_z, 1);
        chk("cmp55 flag_n", bus.flag_n, 0);
        chk("cmp wb_en", bus.wb_en, 0);
        step(1, OP_BEQ, 0, 0, 0, 0);
        chk("beq taken", bus.branch_taken, 1);
        chk("beq valid", bus.ex_valid, 1);

        // CMP 3,7 then BLT
        step(1, OP_CMP, 32'd3, 32'd7, 0, 0);
        step(1, OP_BLT, 0, 0, 0, 0);
        chk("cmp37 flag_n", bus.flag_n, 1);
        chk("blt taken", bus.branch_taken, 1);

        // Overflow boundary: most negative minus one stays negative
        step(1, OP_CMP, 32'h8000_0000, 32'd1, 0, 0);
        chk("cmpmin flag_n", bus.flag_n, 1);
        chk("cmpmin flag_z", bus.flag_z, 0);
        step(1, OP_BNE, 0, 0, 0, 0);
        chk("bne taken", bus.branch_taken, 1);
        chk("bne st_or_bne", bus.st_or_bne, 1);
        step(1, OP_BEQ, 0, 0, 0, 0);
        chk("beq not taken", bus.branch_taken, 0);

        // Plain decode sweep
        foreach (simple_ops[i]) step(1, simple_ops[i], 32'(i), 32'(i + 1), 0, 0);
        chk("jmp jump_en", bus.jump_en, 1);
        chk("jmp taken", bus.branch_taken, 1);
        step(1, OP_ADD, 0, 0, 0, 0);
        chk("add exe_cmd", bus.exe_cmd, EXE_ADD);

        // MULT occupancy with an ADD waiting behind it
        step(1, OP_MULT, 0, 0, 0, 0);
        chk("mult exe_cmd", bus.exe_cmd, EXE_MULT);
        chk("mult wb_en", bus.wb_en, 1);
        chk("mult stall c1", bus.stall_out, 1);
        step(1, OP_ADD, 0, 0, 0, 0);
        chk("mult stall c2", bus.stall_out, 1);
        chk("held add bubble", bus.ex_valid, 0);
        step(1, OP_ADD, 0, 0, 0, 0);
        chk("mult stall c3", bus.stall_out, 1);
        step(1, OP_ADD, 0, 0, 0, 0);
        chk("mult stall end", bus.stall_out, 0);
        chk("add still held", bus.ex_valid, 0);
        step(1, OP_ADD, 0, 0, 0, 0);
        chk("add issues", bus.ex_valid, 1);
        chk("add cmd after mult", bus.exe_cmd, EXE_ADD);

        // Load-use hazard
        step(1, OP_LW, 0, 0, 1, 0);
        chk("hazard bubble", bus.ex_valid, 0);
        chk("hazard mem_r_en", bus.mem_r_en, 0);
        step(1, OP_LW, 0, 0, 0, 0);
        chk("lw mem_r_en", bus.mem_r_en, 1);

        // Flush in BUSY cycle 2 with CMP presented (and hazard too)
        step(1, OP_MULT, 0, 0, 0, 0);
        step(1, OP_ADD, 0, 0, 0, 0);
        chk("busy before flush", bus.stall_out, 1);
        step(1, OP_CMP, 32'd9, 32'd1, 1, 1);
        chk("flush bubble", bus.ex_valid, 0);
        chk("flush stall", bus.stall_out, 0);
        chk("flush keeps flag_n", bus.flag_n, 1);
        step(1, OP_ADD, 0, 0, 0, 0);
        chk("post flush add", bus.ex_valid, 1);

        // Undefined opcode
        step(1, 6'h3F, 0, 0, 0, 0);
        chk("illegal pulse", bus.illegal_op, 1);
        chk("illegal bubble", bus.ex_valid, 0);
        step(1, OP_NOP, 0, 0, 0, 0);
        chk("illegal clears", bus.illegal_op, 0);
        chk("nop valid", bus.ex_valid, 1);
        step(0, OP_ADD, 0, 0, 0, 0);
        chk("idle bubble", bus.ex_valid, 0);

        // Asynchronous reset during MULT
        step(1, OP_MULT, 0, 0, 0, 0);
        bus.in_valid = 0;
        #1 rst = 1'b1;
        #1;
        chk("async rst stall", bus.stall_out, 0);
        chk("async rst ex_valid", bus.ex_valid, 0);
        chk("async rst wb_en", bus.wb_en, 0);
        chk("async rst flag_n", bus.flag_n, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        step(1, OP_BLT, 0, 0, 0, 0);
        chk("blt after rst", bus.branch_taken, 0);
        step(0, OP_NOP, 0, 0, 0, 0);
        step(0, OP_NOP, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
